// File: rtl/tb_status_ctrl.sv
// Multi-channel bench status controller: per-channel check/error tallies, RUN watchdog, PASS/FAIL verdict.
// Optional TB_STATUS_REPORT_EN adds a one-shot verdict print and simulation stop.
module tb_status_ctrl #(
    parameter int CH_N           = 4,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int TMR_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CH_N-1:0]  ch_check,
    input  logic [CH_N-1:0]  ch_err,
    input  logic [CH_N-1:0]  ch_done,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CH_N-1:0]  err_ch_mask
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_e;

    // Wide enough for a saturated counter plus up to 32 strobes in one cycle.
    localparam int SUM_W = ((CNT_W > 6) ? CNT_W : 6) + 1;
    localparam logic [SUM_W-1:0] SAT = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};
    localparam logic [TMR_W-1:0] WD_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] err_q, err_d, chk_q, chk_d;
    logic [CNT_W-1:0] err_nxt, chk_nxt;
    logic [CH_N-1:0]  mask_q, mask_d;
    logic             to_q, to_d;
    logic [TMR_W-1:0] wd_q, wd_d;
    logic             busy_q, done_q, pass_q;
    logic [SUM_W-1:0] err_sum, chk_sum;
    logic             wd_expire;

    always_comb begin
        err_sum = {{(SUM_W-CNT_W){1'b0}}, err_q};
        chk_sum = {{(SUM_W-CNT_W){1'b0}}, chk_q};
        for (int i = 0; i < CH_N; i++) begin
            err_sum = err_sum + {{(SUM_W-1){1'b0}}, ch_err[i]};
            chk_sum = chk_sum + {{(SUM_W-1){1'b0}}, ch_check[i]};
        end
        err_nxt = (err_sum > SAT) ? SAT[CNT_W-1:0] : err_sum[CNT_W-1:0];
        chk_nxt = (chk_sum > SAT) ? SAT[CNT_W-1:0] : chk_sum[CNT_W-1:0];
    end

    assign wd_expire = WD_EN && (wd_q == WD_LAST);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        chk_d   = chk_q;
        mask_d  = mask_q;
        to_d    = to_q;
        wd_d    = wd_q;
        case (state_q)
            S_RUN: begin
                err_d  = err_nxt;
                chk_d  = chk_nxt;
                mask_d = mask_q | ch_err;
                wd_d   = wd_q + 1'b1;
                // All-done takes priority over a watchdog expiring on the same cycle.
                if (&ch_done) begin
                    state_d = ((err_nxt == '0) && (chk_nxt != '0)) ? S_PASS : S_FAIL;
                end else if (wd_expire) begin
                    state_d = S_FAIL;
                    to_d    = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    state_d = S_RUN;
                    err_d   = '0;
                    chk_d   = '0;
                    mask_d  = '0;
                    to_d    = 1'b0;
                    wd_d    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            err_q   <= '0;
            chk_q   <= '0;
            mask_q  <= '0;
            to_q    <= 1'b0;
            wd_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            chk_q   <= chk_d;
            mask_q  <= mask_d;
            to_q    <= to_d;
            wd_q    <= wd_d;
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_PASS) || (state_d == S_FAIL);
            pass_q  <= (state_d == S_PASS);
        end
    end

    assign state       = state_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = to_q;
    assign err_cnt     = err_q;
    assign check_cnt   = chk_q;
    assign err_ch_mask = mask_q;

`ifdef TB_STATUS_REPORT_EN
    logic report_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            report_q <= 1'b0;
        end else begin
            report_q <= (state_q == S_RUN) && ((state_d == S_PASS) || (state_d == S_FAIL));
        end
    end

    // Print one cycle after the verdict edge so the registered totals are final.
    always_ff @(posedge clk) begin
        if (!rst && report_q) begin
            if (state_q == S_PASS) $display("!@# TEST PASSED #@!");
            else                   $display("!@# TEST FAILED #@!");
            $display("err_cnt=%0d check_cnt=%0d timeout=%0d", err_q, chk_q, to_q);
`ifdef __ICARUS__
            $finish;
`else
            $stop;
`endif
        end
    end
`endif

endmodule
